// File: rtl/dest_drain_arbiter.sv
// Egress stage: pops the D0/D1 destination FIFOs, arbitrates and merges them into one
// destination-tagged valid/ready stream. Define STRICT_PRIO_D0_EN for strict D0 priority.
module dest_drain_arbiter #(
  parameter int BW         = 6,
  parameter int OUTQ_DEPTH = 4,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          D0_empty,
  input  logic [BW-1:0] D0_data_out,
  input  logic          D1_empty,
  input  logic [BW-1:0] D1_data_out,
  output logic          D0_rd,
  output logic          D1_rd,
  output logic [BW-1:0] data_out,
  output logic          dest_out,
  output logic          valid_out,
  input  logic          out_ready,
  output logic [CW-1:0] cnt_D0,
  output logic [CW-1:0] cnt_D1,
  output logic          idle
);

  localparam int AW = $clog2(OUTQ_DEPTH);
  localparam logic [AW:0] QDepth = OUTQ_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  state_e        state_q;
  logic [BW:0]   mem_q [OUTQ_DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   occ_q;
  logic [AW:0]   occ_d;
  logic          pend_q;
  logic          pendDest_q;
  logic [CW-1:0] cnt0_q;
  logic [CW-1:0] cnt1_q;
  logic          deq;
  logic          grant0;
  logic          grant1;
  logic          popEn;

  assign valid_out           = (occ_q != '0);
  assign deq                 = valid_out & out_ready;
  assign {dest_out, data_out} = mem_q[rdPtr_q];
  assign cnt_D0              = cnt0_q;
  assign cnt_D1              = cnt1_q;
  assign idle                = (state_q == IDLE);

  // Occupancy after this cycle counts the word still in flight from last cycle's pop,
  // so granting only while it stays below depth can never overflow the queue.
  assign occ_d = occ_q + {{AW{1'b0}}, pend_q} - {{AW{1'b0}}, deq};
  assign popEn = (state_q == RUN) && enable && !reset && (occ_d < QDepth);

  assign D0_rd = popEn & grant0;
  assign D1_rd = popEn & grant1;

`ifdef STRICT_PRIO_D0_EN
  assign grant0 = !D0_empty;
  assign grant1 = D0_empty && !D1_empty;
`else
  logic rr_q;

  always_comb begin
    grant0 = !D0_empty;
    grant1 = !D1_empty;
    if (!D0_empty && !D1_empty) begin
      grant0 = !rr_q;
      grant1 = rr_q;
    end
  end

  // The pointer only moves when both sides actually competed for the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else if (popEn && !D0_empty && !D1_empty) begin
      rr_q <= !rr_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      occ_q      <= '0;
      pend_q     <= 1'b0;
      pendDest_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      for (int i = 0; i < OUTQ_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: if (enable) state_q <= RUN;
        RUN:  if (!enable) state_q <= STOP;
        STOP: begin
          if (enable) begin
            state_q <= RUN;
          end else if (!pend_q && occ_q == '0) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      pend_q     <= D0_rd | D1_rd;
      pendDest_q <= D1_rd;

      // FIFO read data is valid the cycle after the pop strobe.
      if (pend_q) begin
        mem_q[wrPtr_q] <= {pendDest_q, pendDest_q ? D1_data_out : D0_data_out};
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (deq) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      occ_q <= occ_d;

      if (deq && !dest_out) cnt0_q <= cnt0_q + 1'b1;
      if (deq && dest_out)  cnt1_q <= cnt1_q + 1'b1;
    end
  end

endmodule
